// File: rtl/cpu_pkg.sv
// Shared definitions for the core's execute path.
// Holds the control-field encodings (ALU op, branch kind, operand-B source,
// destination select), the divider FSM states and the fixed constants.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_DIVU = 4'd12,
    ALU_REMU = 4'd13,
    ALU_PASS = 4'd14,
    ALU_ZERO = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_J    = 2'd3
  } branch_e;

  typedef enum logic [1:0] {
    SRC_RT   = 2'd0,
    SRC_SIMM = 2'd1,
    SRC_ZIMM = 2'd2,
    SRC_SA   = 2'd3
  } alusrc_e;

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_LINK = 2'd2,
    DST_ZERO = 2'd3
  } regdist_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int REG_LINK  = 31;
  localparam int DIV_STEPS = 32;

endpackage

// File: rtl/divider_iter.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   CLK, reset        clock, async active-low reset
//   start             accept dividend/divisor (honoured only in IDLE)
//   dividend, divisor 32-bit operands
//   busy              FSM not in IDLE
//   done              FSM in DONE; quotient/remainder are final this cycle
//   quotient, remainder results (divisor 0 gives all-ones / dividend)
//   state             FSM state, for observation
module divider_iter
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [1:0]  state
);

  div_state_e  r_state;
  div_state_e  w_state_next;
  logic [4:0]  r_count;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;

  // Partial remainder shifted left with the next dividend bit (taken from
  // the top of the quotient register, which doubles as the dividend shifter).
  // Bit 32 of the difference is the borrow: set means the trial did not fit.
  // A zero divisor always fits, which yields the all-ones quotient and
  // leaves the dividend in the remainder without any special casing.
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_fits;

  assign w_trial = {r_rem, r_quo[31]};
  assign w_diff  = w_trial - {1'b0, r_dvs};
  assign w_fits  = ~w_diff[32];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: if (start) w_state_next = DIV_RUN;
      DIV_RUN:  if (r_count == 5'(DIV_STEPS - 1)) w_state_next = DIV_DONE;
      DIV_DONE: w_state_next = DIV_IDLE;
      default:  w_state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= DIV_IDLE;
      r_count <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == DIV_IDLE && start) begin
        r_quo   <= dividend;
        r_rem   <= '0;
        r_dvs   <= divisor;
        r_count <= '0;
      end else if (r_state == DIV_RUN) begin
        r_count <= r_count + 5'd1;
        r_quo   <= {r_quo[30:0], w_fits};
        r_rem   <= w_fits ? w_diff[31:0] : w_trial[31:0];
      end
    end
  end

  assign busy      = (r_state != DIV_IDLE);
  assign done      = (r_state == DIV_DONE);
  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign state     = r_state;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand muxes, ALU, branch resolution, destination select
// and the pipeline register feeding the memory stage. DIVU/REMU go to the
// iterative divider; while it works the stage asserts busy and the output
// register carries bubbles.
// Handshake: busy is combinational. While busy is high the upstream stage
// holds its outputs; an instruction presented while busy is low is consumed
// at the next rising edge. A divide presented in IDLE is consumed at that
// edge even though busy is already high in its own cycle.
// Ports: CLK/reset; in_valid + operands + control word in; *_next pipeline
// register out; branch_taken/branch_target registered alongside valid_next;
// dbg_div_state exposes the divider FSM.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [31:0]               op1_sub,
  input  logic [31:0]               op2_sub,
  input  logic                      AorF,
  input  logic                      distinct,
  input  logic                      RegWrite,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic                      RegtoUART,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                ALUSrcs,
  input  logic [1:0]                RegDist,
  input  logic [1:0]                Branch,
  input  logic                      ALUSrcs2,
  input  logic [3:0]                ALUOp,
  input  logic [4:0]                rt,
  input  logic [4:0]                rd,
  input  logic [4:0]                sa,
  input  logic [15:0]               immediate,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  output logic                      busy,
  output logic                      valid_next,
  output logic [31:0]               alu_result_next,
  output logic [31:0]               mem_wdata_next,
  output logic [4:0]                rw_next,
  output logic                      AorF_next,
  output logic                      distinct_next,
  output logic                      RegWrite_next,
  output logic                      MemWrite_next,
  output logic                      MemRead_next,
  output logic                      UARTtoReg_next,
  output logic                      RegtoUART_next,
  output logic [1:0]                MemtoReg_next,
  output logic                      branch_taken,
  output logic [INST_MEM_WIDTH-1:0] branch_target,
  output logic [1:0]                dbg_div_state
);

  localparam int W = INST_MEM_WIDTH;

  logic [31:0]  w_b;
  logic [4:0]   w_shamt;
  logic [31:0]  w_alu;
  logic [31:0]  w_result;
  logic [4:0]   w_rw;
  logic         w_taken;
  logic [W-1:0] w_target;
  logic         w_is_div;
  logic         w_div_start;
  logic         w_div_busy;
  logic         w_div_done;
  logic [31:0]  w_quo;
  logic [31:0]  w_rem;
  logic         w_unused;

  assign w_unused = ^{pc, inst_index[25:W]};

  // Operand B and shift amount.
  always_comb begin
    w_b = op2_sub;
    case (alusrc_e'(ALUSrcs))
      SRC_RT:   w_b = op2_sub;
      SRC_SIMM: w_b = {{16{immediate[15]}}, immediate};
      SRC_ZIMM: w_b = {16'h0, immediate};
      SRC_SA:   w_b = {27'h0, sa};
      default:  w_b = op2_sub;
    endcase
  end

  assign w_shamt = ALUSrcs2 ? op1_sub[4:0] : sa;

  always_comb begin
    w_alu = '0;
    case (alu_op_e'(ALUOp))
      ALU_ADD:  w_alu = op1_sub + w_b;
      ALU_SUB:  w_alu = op1_sub - w_b;
      ALU_AND:  w_alu = op1_sub & w_b;
      ALU_OR:   w_alu = op1_sub | w_b;
      ALU_XOR:  w_alu = op1_sub ^ w_b;
      ALU_NOR:  w_alu = ~(op1_sub | w_b);
      ALU_SLT:  w_alu = {31'h0, $signed(op1_sub) < $signed(w_b)};
      ALU_SLTU: w_alu = {31'h0, op1_sub < w_b};
      ALU_SLL:  w_alu = w_b << w_shamt;
      ALU_SRL:  w_alu = w_b >> w_shamt;
      ALU_SRA:  w_alu = $signed(w_b) >>> w_shamt;
      ALU_LUI:  w_alu = {immediate, 16'h0};
      ALU_PASS: w_alu = w_b;
      default:  w_alu = '0; // ZERO; DIVU/REMU results come from the divider
    endcase
  end

  assign w_result = (regdist_e'(RegDist) == DST_LINK)
                    ? {{(32-W){1'b0}}, pc1} : w_alu;

  always_comb begin
    w_rw = rt;
    case (regdist_e'(RegDist))
      DST_RT:   w_rw = rt;
      DST_RD:   w_rw = rd;
      DST_LINK: w_rw = 5'(REG_LINK);
      default:  w_rw = 5'd0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (branch_e'(Branch))
      BR_BEQ:  w_taken = (op1_sub == op2_sub);
      BR_BNE:  w_taken = (op1_sub != op2_sub);
      BR_J:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_target = (branch_e'(Branch) == BR_J) ? inst_index[W-1:0]
                                                 : pc1 + immediate[W-1:0];

  assign w_is_div    = (alu_op_e'(ALUOp) == ALU_DIVU) || (alu_op_e'(ALUOp) == ALU_REMU);
  assign w_div_start = in_valid && w_is_div && !w_div_busy;
  assign busy        = w_div_busy || w_div_start;

  divider_iter u_div (
    .CLK       (CLK),
    .reset     (reset),
    .start     (w_div_start),
    .dividend  (op1_sub),
    .divisor   (op2_sub),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem),
    .state     (dbg_div_state)
  );

  // Control word of the divide in flight; replayed into the output
  // register when the divider reaches DONE.
  logic         r_d_rem;
  logic [4:0]   r_d_rw;
  logic [31:0]  r_d_wdata;
  logic [6:0]   r_d_bits;
  logic [1:0]   r_d_memtoreg;
  logic         r_d_taken;
  logic [W-1:0] r_d_target;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_d_rem      <= 1'b0;
      r_d_rw       <= '0;
      r_d_wdata    <= '0;
      r_d_bits     <= '0;
      r_d_memtoreg <= '0;
      r_d_taken    <= 1'b0;
      r_d_target   <= '0;
    end else if (w_div_start) begin
      r_d_rem      <= (alu_op_e'(ALUOp) == ALU_REMU);
      r_d_rw       <= w_rw;
      r_d_wdata    <= op2_sub;
      r_d_bits     <= {AorF, distinct, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART};
      r_d_memtoreg <= MemtoReg;
      r_d_taken    <= w_taken;
      r_d_target   <= w_target;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      valid_next      <= 1'b0;
      alu_result_next <= '0;
      mem_wdata_next  <= '0;
      rw_next         <= '0;
      AorF_next       <= 1'b0;
      distinct_next   <= 1'b0;
      RegWrite_next   <= 1'b0;
      MemWrite_next   <= 1'b0;
      MemRead_next    <= 1'b0;
      UARTtoReg_next  <= 1'b0;
      RegtoUART_next  <= 1'b0;
      MemtoReg_next   <= '0;
      branch_taken    <= 1'b0;
      branch_target   <= '0;
    end else if (w_div_done) begin
      valid_next      <= 1'b1;
      alu_result_next <= r_d_rem ? w_rem : w_quo;
      mem_wdata_next  <= r_d_wdata;
      rw_next         <= r_d_rw;
      {AorF_next, distinct_next, RegWrite_next, MemWrite_next,
       MemRead_next, UARTtoReg_next, RegtoUART_next} <= r_d_bits;
      MemtoReg_next   <= r_d_memtoreg;
      branch_taken    <= r_d_taken;
      branch_target   <= r_d_target;
    end else if (busy) begin
      // Accept cycle and iterations: bubble, side-effect bits cleared.
      valid_next      <= 1'b0;
      RegWrite_next   <= 1'b0;
      MemWrite_next   <= 1'b0;
      MemRead_next    <= 1'b0;
      UARTtoReg_next  <= 1'b0;
      RegtoUART_next  <= 1'b0;
      branch_taken    <= 1'b0;
    end else begin
      valid_next      <= in_valid;
      alu_result_next <= w_result;
      mem_wdata_next  <= op2_sub;
      rw_next         <= w_rw;
      AorF_next       <= AorF;
      distinct_next   <= distinct;
      RegWrite_next   <= in_valid && RegWrite;
      MemWrite_next   <= in_valid && MemWrite;
      MemRead_next    <= in_valid && MemRead;
      UARTtoReg_next  <= in_valid && UARTtoReg;
      RegtoUART_next  <= in_valid && RegtoUART;
      MemtoReg_next   <= MemtoReg;
      branch_taken    <= in_valid && w_taken;
      branch_target   <= w_target;
    end
  end

endmodule
